// File: rtl/spi_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_tx_pkg
// Brief   : Shared types and default constants for the SPI transmit stream.
// Revision: 1.0
// ============================================================================
package spi_tx_pkg;

    localparam int SPI_TX_DATA_W_DEF     = 8;
    localparam int SPI_TX_FIFO_DEPTH_DEF = 16;
    localparam int SPI_TX_MSB_FIRST_DEF  = 1;
    localparam int SPI_TX_CNT_W_DEF      = 16;

    // Pattern shifted during starved slots when fill is enabled; LSBs are used.
    localparam logic [31:0] SPI_TX_FILL_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_STARVE = 2'd2
    } spi_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : spi_tx_fifo
// Brief   : Single-clock first-word-fall-through word buffer with level output.
// Revision: 1.0
// ============================================================================
module spi_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic                       rd_pop_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;
    logic              ready_q;
    logic              w_push;
    logic              w_pop;

    // Ready is registered from the next level so a full buffer refuses a push
    // even when a pop frees a slot on the same edge.
    assign wr_ready_o = rst_ni & ready_q;
    assign w_push     = wr_valid_i & wr_ready_o;
    assign w_pop      = rd_pop_i & (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;

endmodule
`default_nettype wire

// File: rtl/spi_tx_stream.sv
`default_nettype none
// ============================================================================
// Module  : spi_tx_stream
// Brief   : SPI slave transmit path clocked by sck: buffers words and shifts
//           them out on miso while cs_n is low. Define SPI_TX_UNDERRUN_FILL_EN
//           to shift SPI_TX_FILL_WORD instead of zeros during starved slots.
// Revision: 1.0
// ============================================================================
module spi_tx_stream
    import spi_tx_pkg::*;
#(
    parameter int DATA_W     = SPI_TX_DATA_W_DEF,
    parameter int FIFO_DEPTH = SPI_TX_FIFO_DEPTH_DEF,
    parameter int MSB_FIRST  = SPI_TX_MSB_FIRST_DEF,
    parameter int CNT_W      = SPI_TX_CNT_W_DEF
) (
    input  logic                            sck,
    input  logic                            sys_rst_n,
    input  logic [DATA_W-1:0]               data_in,
    input  logic                            valid,
    output logic                            ready,
    input  logic                            cs_n,
    output logic                            miso,
    output logic [$clog2(DATA_W)-1:0]       bit_cnt,
    output logic [CNT_W-1:0]                sent_cnt,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun
);

    localparam int              BCW      = $clog2(DATA_W);
    localparam int              LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_W - 1);
`ifdef SPI_TX_UNDERRUN_FILL_EN
    localparam logic [DATA_W-1:0] FILL = SPI_TX_FILL_WORD[DATA_W-1:0];
`else
    localparam logic [DATA_W-1:0] FILL = '0;
`endif

    spi_tx_state_e     state_q;
    logic [DATA_W-1:0] sreg_q;
    logic              miso_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]  sent_cnt_q;
    logic              underrun_q;

    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_load_word;
    logic [DATA_W-1:0] w_load_rest;
    logic [DATA_W-1:0] w_sreg_rest;
    logic              w_load_first;
    logic              w_sreg_first;
    logic              w_empty;
    logic              w_boundary;
    logic              w_pop;
    logic [LW-1:0]     w_level;

    assign w_boundary  = (bit_cnt_q == '0);
    assign w_pop       = sys_rst_n & ~cs_n & w_boundary & ~w_empty;
    assign w_load_word = w_empty ? FILL : w_head;

    spi_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (sck),
        .rst_ni     (sys_rst_n),
        .wr_data_i  (data_in),
        .wr_valid_i (valid),
        .wr_ready_o (ready),
        .rd_pop_i   (w_pop),
        .rd_data_o  (w_head),
        .empty_o    (w_empty),
        .level_o    (w_level)
    );

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_load_first = w_load_word[DATA_W-1];
            assign w_load_rest  = {w_load_word[DATA_W-2:0], 1'b0};
            assign w_sreg_first = sreg_q[DATA_W-1];
            assign w_sreg_rest  = {sreg_q[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_load_first = w_load_word[0];
            assign w_load_rest  = {1'b0, w_load_word[DATA_W-1:1]};
            assign w_sreg_first = sreg_q[0];
            assign w_sreg_rest  = {1'b0, sreg_q[DATA_W-1:1]};
        end
    endgenerate

    // The first bit of each slot is registered on the same edge that loads it,
    // so miso carries data from the very first low-cs_n edge.
    always_ff @(posedge sck) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            miso_q     <= 1'b0;
            bit_cnt_q  <= '0;
            sent_cnt_q <= '0;
            underrun_q <= 1'b0;
        end else if (cs_n) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            miso_q     <= 1'b0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
        end else if (w_boundary) begin
            sreg_q    <= w_load_rest;
            miso_q    <= w_load_first;
            bit_cnt_q <= BCW'(1);
            if (w_empty) begin
                state_q    <= ST_STARVE;
                underrun_q <= 1'b1;
            end else begin
                state_q <= ST_SHIFT;
            end
        end else begin
            sreg_q <= w_sreg_rest;
            miso_q <= w_sreg_first;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                if (state_q == ST_SHIFT) begin
                    sent_cnt_q <= sent_cnt_q + CNT_W'(1);
                end
            end else begin
                bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
        end
    end

    assign miso       = miso_q;
    assign bit_cnt    = bit_cnt_q;
    assign sent_cnt   = sent_cnt_q;
    assign fifo_level = w_level;
    assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_tx_stream
// Brief   : Self-checking bench for spi_tx_stream, MSB-first and LSB-first.
// Revision: 1.0
// ============================================================================
module tb_spi_tx_stream;

    localparam int DEPTH = 16;
`ifdef SPI_TX_UNDERRUN_FILL_EN
    localparam logic [7:0] FILL_EXP = 8'hFF;
`else
    localparam logic [7:0] FILL_EXP = 8'h00;
`endif

    logic       sck       = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       valid     = 1'b0;
    logic       cs_n      = 1'b1;
    logic [7:0] data_in   = 8'h00;

    logic        ready_m, miso_m, und_m;
    logic [2:0]  bit_cnt_m;
    logic [15:0] sent_m;
    logic [4:0]  level_m;
    logic        ready_l, miso_l, und_l;
    logic [2:0]  bit_cnt_l;
    logic [15:0] sent_l;
    logic [4:0]  level_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 sck = ~sck;

    spi_tx_stream #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1), .CNT_W(16)) dut_m (
        .sck(sck), .sys_rst_n(sys_rst_n), .data_in(data_in), .valid(valid),
        .ready(ready_m), .cs_n(cs_n), .miso(miso_m), .bit_cnt(bit_cnt_m),
        .sent_cnt(sent_m), .fifo_level(level_m), .underrun(und_m)
    );

    spi_tx_stream #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0), .CNT_W(16)) dut_l (
        .sck(sck), .sys_rst_n(sys_rst_n), .data_in(data_in), .valid(valid),
        .ready(ready_l), .cs_n(cs_n), .miso(miso_l), .bit_cnt(bit_cnt_l),
        .sent_cnt(sent_l), .fifo_level(level_l), .underrun(und_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the slot currently on the wire.
    logic [7:0] q[$];
    logic [7:0] m_word = 8'h00;
    bit         m_real = 1'b0;
    int         m_idx  = 0;
    int         m_sent = 0;
    bit         m_und  = 1'b0;
    bit         m_bm   = 1'b0;
    bit         m_bl   = 1'b0;
    bit         m_alive = 1'b0;
    bit         m_on   = 1'b0;

    always @(posedge sck) begin
        bit push_ok;
        push_ok = sys_rst_n && valid && m_alive && (q.size() < DEPTH);
        if (!sys_rst_n) begin
            q.delete();
            m_idx = 0; m_sent = 0; m_und = 1'b0;
            m_bm = 1'b0; m_bl = 1'b0; m_alive = 1'b0; m_on = 1'b1;
        end else begin
            m_alive = 1'b1;
            if (cs_n) begin
                m_idx = 0; m_und = 1'b0; m_bm = 1'b0; m_bl = 1'b0;
            end else begin
                if (m_idx == 0) begin
                    if (q.size() > 0) begin
                        m_word = q.pop_front();
                        m_real = 1'b1;
                    end else begin
                        m_word = FILL_EXP;
                        m_real = 1'b0;
                        m_und  = 1'b1;
                    end
                end
                m_bm = m_word[7 - m_idx];
                m_bl = m_word[m_idx];
                m_idx++;
                if (m_idx == 8) begin
                    m_idx = 0;
                    if (m_real) m_sent = (m_sent + 1) % 65536;
                end
            end
            if (push_ok) q.push_back(data_in);
        end
    end

    always @(negedge sck) begin
        bit e_rdy;
        if (m_on) begin
            e_rdy = sys_rst_n && m_alive && (q.size() < DEPTH);
            chk("ready_m",  ready_m,   e_rdy);
            chk("ready_l",  ready_l,   e_rdy);
            chk("miso_m",   miso_m,    m_bm);
            chk("miso_l",   miso_l,    m_bl);
            chk("bitcnt_m", bit_cnt_m, m_idx);
            chk("bitcnt_l", bit_cnt_l, m_idx);
            chk("sent_m",   sent_m,    m_sent);
            chk("sent_l",   sent_l,    m_sent);
            chk("level_m",  level_m,   q.size());
            chk("level_l",  level_l,   q.size());
            chk("under_m",  und_m,     m_und);
            chk("under_l",  und_l,     m_und);
        end
    end

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        valid   = 1'b1;
        data_in = w;
        tick();
        valid   = 1'b0;
    endtask

    // Holds cs_n low for n edges; returns the last 8 bits seen on each miso.
    task automatic run_cs(input int n, output logic [7:0] cm, output logic [7:0] cl,
                          output logic [7:0] rl);
        cm = 8'h00; cl = 8'h00; rl = 8'h00;
        cs_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            cm = {cm[6:0], miso_m};
            cl = {miso_l, cl[7:1]};
            rl = {rl[6:0], miso_l};
        end
    endtask

    initial begin
        logic [7:0] cm, cl, rl, last_w;

        sys_rst_n = 1'b0; cs_n = 1'b1; valid = 1'b0;
        tick(); tick();
        chk("rst_ready", ready_m, 1'b0);
        chk("rst_level", level_m, 5'd0);
        chk("rst_miso",  miso_m,  1'b0);
        sys_rst_n = 1'b1;
        chk("ready_before_edge", ready_m, 1'b0);
        tick();
        chk("ready_after_edge", ready_m, 1'b1);

        push(8'hA5);
        run_cs(8, cm, cl, rl);
        chk("a5_msb_word", cm, 8'hA5);
        chk("a5_lsb_word", cl, 8'hA5);
        chk("a5_sent", sent_m, 16'd1);
        cs_n = 1'b1; tick();

        push(8'h01);
        run_cs(8, cm, cl, rl);
        chk("lsb01_seq", rl, 8'h80);
        chk("msb01_seq", cm, 8'h01);
        chk("01_sent", sent_l, 16'd2);
        cs_n = 1'b1; tick();

        valid  = 1'b1;
        last_w = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last_w  = 8'($urandom);
            data_in = last_w;
            tick();
        end
        chk("full_ready", ready_m, 1'b0);
        chk("full_level", level_m, 5'd16);
        data_in = 8'hEE;
        tick();
        valid = 1'b0;
        chk("drop17_level", level_m, 5'd16);
        run_cs(128, cm, cl, rl);
        chk("drain_last", cm, last_w);
        chk("drain_sent", sent_m, 16'd18);
        chk("drain_level", level_m, 5'd0);
        cs_n = 1'b1; tick();

        run_cs(8, cm, cl, rl);
        chk("starve_miso", cm, FILL_EXP);
        chk("starve_flag", und_m, 1'b1);
        chk("starve_sent", sent_m, 16'd18);
        cs_n = 1'b1; tick();
        chk("starve_clear", und_m, 1'b0);

        push(8'hC3);
        push(8'h3C);
        run_cs(3, cm, cl, rl);
        chk("c3_partial", {29'd0, cm[2:0]}, 32'd6);
        cs_n = 1'b1; tick();
        run_cs(8, cm, cl, rl);
        chk("abort_next", cm, 8'h3C);
        chk("abort_sent", sent_m, 16'd19);
        cs_n = 1'b1; tick();

        for (int i = 1; i <= 5; i++) push(8'(i * 17));
        run_cs(4, cm, cl, rl);
        chk("pre_rst_level", level_m, 5'd4);
        sys_rst_n = 1'b0;
        tick();
        chk("mid_rst_level", level_m, 5'd0);
        chk("mid_rst_miso",  miso_m, 1'b0);
        chk("mid_rst_bits",  bit_cnt_m, 3'd0);
        chk("mid_rst_sent",  sent_m, 16'd0);
        chk("mid_rst_under", und_m, 1'b0);
        chk("mid_rst_ready", ready_m, 1'b0);
        sys_rst_n = 1'b1; cs_n = 1'b1;
        tick();
        chk("post_rst_ready", ready_m, 1'b1);

        for (int c = 0; c < 4000; c++) begin
            valid     = ($urandom_range(99) < (((c / 400) % 2 == 1) ? 85 : 25));
            data_in   = 8'($urandom);
            if ($urandom_range(99) < 4) cs_n = ~cs_n;
            sys_rst_n = ($urandom_range(999) != 0);
            tick();
        end
        valid = 1'b0; cs_n = 1'b1; sys_rst_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_tx_stream.md
SPI_TX_STREAM -- requirements
Module: spi_tx_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (4..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, word buffer depth (power of 2, >=2).
REQ-003 SHALL have parameter MSB_FIRST, default 1, shift order (1 = MSB first, 0 = LSB first).
REQ-004 SHALL have parameter CNT_W, default 16, width of sent_cnt.
REQ-005 SHALL have port sck  input  1  sole clock (SPI clock); all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port data_in  input  DATA_W  word to enqueue.
REQ-008 SHALL have port valid  input  1  data_in valid.
REQ-009 SHALL have port ready  output  1  FIFO can accept a word.
REQ-010 SHALL have port cs_n  input  1  chip select, active-low frame.
REQ-011 SHALL have port miso  output  1  serial data out, registered.
REQ-012 SHALL have port bit_cnt  output  clog2(DATA_W)  bit index within the current word slot.
REQ-013 SHALL have port sent_cnt  output  CNT_W  completed-word count.
REQ-014 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  words buffered.
REQ-015 SHALL have port underrun  output  1  sticky: a word slot found the FIFO empty.

Function
REQ-016 SHALL push data_in into the FIFO on a rising edge where valid=1 and ready=1, independent of cs_n.
REQ-017 SHALL drive ready = 1 when fifo_level < FIFO_DEPTH, otherwise 0; a push while full SHALL be dropped, even if a pop occurs on the same edge.
REQ-018 SHALL, on simultaneous push and pop with the FIFO not full, leave fifo_level unchanged.
REQ-019 SHALL implement the states IDLE, SHIFT and STARVE.
- IDLE -> SHIFT: cs_n=0 and FIFO non-empty.
- IDLE -> STARVE: cs_n=0 and FIFO empty.
- Any state -> IDLE: cs_n=1.
REQ-020 SHALL, at each word boundary (bit_cnt=0) with cs_n=0, pop one word into the shift register and register its first bit on miso on that same edge: zero latency from the first low-cs_n edge.
REQ-021 SHALL shift one bit per edge in SHIFT, with order set by MSB_FIRST.
REQ-022 SHALL wrap bit_cnt from DATA_W-1 to 0 and, on that wrap, increment sent_cnt modulo 2^CNT_W.
REQ-023 SHALL, when a boundary finds the FIFO empty, enter STARVE, set underrun, drive miso=0 for the whole slot, and not increment sent_cnt.
REQ-024 SHALL leave STARVE for SHIFT at the next boundary at which the FIFO is non-empty.
REQ-025 SHALL, when cs_n=1, hold miso=0 and bit_cnt=0.
REQ-026 SHALL discard the remainder of a word interrupted by cs_n=1 mid-word, not re-send it, and not count it.
REQ-027 SHALL clear underrun on the first edge with cs_n=1.

Reset
REQ-028 SHALL, on an edge with sys_rst_n=0, clear the FIFO and reset all outputs: miso=0, bit_cnt=0, sent_cnt=0, fifo_level=0, underrun=0, state=IDLE.
REQ-029 SHALL force ready=0 while sys_rst_n=0, and ready=1 after the first edge with sys_rst_n=1.
REQ-030 SHALL let reset asserted mid-word abort the word, with no partial count.

Configuration
REQ-031 SHALL support macro SPI_TX_UNDERRUN_FILL_EN:
- Defined: STARVE slots shift the constant SPI_TX_FILL_WORD from the package, in the order set by MSB_FIRST.
- Undefined: STARVE slots shift zeros.
- underrun flag and count behaviour SHALL be identical either way.

Structure
REQ-032 SHALL keep the state enum, SPI_TX_FILL_WORD and the default parameter constants in shared package spi_tx_pkg.
REQ-033 SHALL implement the buffer as sub-module spi_tx_fifo (synchronous, single clock, first-word-fall-through, level output).

Verification
REQ-034 SHALL cover: push 0xA5 with cs_n high, then cs_n low for 8 edges -> miso 1,0,1,0,0,1,0,1 and sent_cnt=1.
REQ-035 SHALL cover: MSB_FIRST=0, push 0x01 -> miso 1,0,0,0,0,0,0,0.
REQ-036 SHALL cover: 16 pushes then a 17th with valid=1 -> ready=0, 17th dropped, fifo_level=16.
REQ-037 SHALL cover: cs_n low with FIFO empty for 8 edges -> underrun=1, miso all 0 (0xFF fill with macro), sent_cnt unchanged.
REQ-038 SHALL cover: cs_n high after 3 bits of 0xC3, then 0x3C sent -> 0xC3 remainder lost, next slot shifts 0x3C, sent_cnt +1 only.
REQ-039 SHALL cover: sys_rst_n low for one edge mid-word with 5 words queued -> fifo_level=0, all outputs 0.
